// File: rtl/rr_arbiter4_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg: shared types and constants for the rr_arbiter4 block.
//   state_t  : arbiter FSM states (IDLE, GRANT, RELEASE)
//   NUM_REQ  : number of requesters (4)
//   IDX_W    : width of a requester index (2)
//   GNT_NONE : active-low grant vector with no owner
//   rr_pick  : round-robin search helper
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    localparam logic [NUM_REQ-1:0] GNT_NONE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scan ptr+1, ptr+2, ptr+3, ptr (2-bit wrap) and return the first set request.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!p.found && req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter4_if: request/grant bundle between the requesters and the arbiter.
//   en_n      : active-low arbiter enable
//   req       : active-high requests, bit i = requester i
//   gnt_n     : registered active-low one-hot grant
//   gnt_idx   : index of the current or last owner
//   gnt_valid : high while a grant is asserted
//   timeout   : one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface rr_arbiter4_if;
    import arb_pkg::*;

    logic               en_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt_n;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               timeout;

    modport master (
        output en_n, req,
        input  gnt_n, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  en_n, req,
        output gnt_n, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_arbiter4_dec.sv
// -----------------------------------------------------------------------------
// grant_dec2to4: combinational 2-to-4 active-low decoder.
//   en_n : active-low enable; 1 forces all outputs high
//   idx  : index to select
//   y_n  : active-low one-hot output (1111 when disabled)
// -----------------------------------------------------------------------------
module grant_dec2to4
    import arb_pkg::*;
(
    input  logic               en_n,
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] y_n
);

    // NOTE: every output of an always_comb gets a value before any branch,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        y_n = GNT_NONE;
        if (!en_n) begin
            y_n[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4: four-requester round-robin arbiter with a one-cycle dead time
// between owners and a registered active-low one-hot grant.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : rr_arbiter4_if.slave (en_n, req in; gnt_n, gnt_idx, gnt_valid,
//          timeout out)
// Parameter TIMEOUT (2..255): max GRANT cycles per ownership.
// Optional feature macro: ARB_TIMEOUT_EN builds the ownership timeout counter;
// when undefined, timeout is tied low and a grant is held indefinitely.
// -----------------------------------------------------------------------------
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter4_if.slave bus
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_arbiter4: TIMEOUT must be in 2..255");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] gnt_n_q, gnt_n_d;
    logic               valid_q, valid_d;

    pick_t              pick;
    logic               load;
    logic               expire;
    logic [NUM_REQ-1:0] dec_y_n;

    assign pick = rr_pick(bus.req, ptr_q);
    assign load = (state_q == IDLE) && !bus.en_n && pick.found;

    // The decoder output is only used on the cycle a new owner is loaded.
    grant_dec2to4 u_dec (
        .en_n (~load),
        .idx  (pick.idx),
        .y_n  (dec_y_n)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_n_d = gnt_n_q;
        valid_d = valid_q;
        if (bus.en_n) begin
            // Abort: drop the grant but leave ptr alone, so the owner is not
            // treated as served.
            state_d = IDLE;
            gnt_n_d = GNT_NONE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        idx_d   = pick.idx;
                        gnt_n_d = dec_y_n;
                        valid_d = 1'b1;
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.req[idx_q] || expire) begin
                        gnt_n_d = GNT_NONE;
                        valid_d = 1'b0;
                        ptr_d   = idx_q;
                        state_d = RELEASE;
                    end
                end
                RELEASE: state_d = IDLE;
                default: begin
                    state_d = IDLE;
                    gnt_n_d = GNT_NONE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            idx_q   <= '0;
            gnt_n_q <= GNT_NONE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_n_q <= gnt_n_d;
            valid_q <= valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    // Counter is 0 on the first GRANT cycle, so TIMEOUT-1 marks the last one.
    assign expire = (state_q == GRANT) && (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (load) begin
            cnt_d = '0;
        end else if (state_q == GRANT) begin
            cnt_d = cnt_q + 8'd1;
        end
        // Only a release caused by the counter (owner still requesting) pulses.
        timeout_d = !bus.en_n && expire && bus.req[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt_n     = gnt_n_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;

endmodule
